// File: rtl/usb_rx_pkg.sv
// Shared types and pin encodings for the USB receive front end.
package usb_rx_pkg;

    typedef enum logic [1:0] {LsJ, LsK, LsSe0, LsSe1} line_state_t;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StEop1,
        StEop2,
        StAbort
    } rx_state_t;

    // Pin encodings as {rx_dp, rx_dm}.
    localparam logic [1:0] PinsJ   = 2'b10;
    localparam logic [1:0] PinsK   = 2'b01;
    localparam logic [1:0] PinsSe0 = 2'b00;
    localparam logic [1:0] PinsSe1 = 2'b11;

    localparam int unsigned SyncMinZeros = 5;

endpackage

// File: rtl/usb_nrzi_decode.sv
// Classifies the D+/D- sample into a line state and NRZI-decodes it against the previous J/K level.
module usb_nrzi_decode
    import usb_rx_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_dp,
    input  logic        rx_dm,
    output line_state_t line_state,
    output logic        dec_bit
);

    // 1 = J level, 0 = K level; SE0/SE1 leave it untouched.
    logic prev_level;

    always_comb begin
        line_state = LsSe1;
        case ({rx_dp, rx_dm})
            PinsJ:   line_state = LsJ;
            PinsK:   line_state = LsK;
            PinsSe0: line_state = LsSe0;
            default: line_state = LsSe1;
        endcase
    end

    assign dec_bit = (rx_dp == prev_level);

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_level <= 1'b1;
        end else if (line_state == LsJ || line_state == LsK) begin
            prev_level <= rx_dp;
        end
    end

endmodule

// File: rtl/usb_rx_unstuff.sv
// Receive FSM: SYNC/EOP detection, bit unstuffing and packet length policing.
module usb_rx_unstuff
    import usb_rx_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 6,
    parameter int unsigned MAX_BITS  = 1100,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_dp,
    input  logic             rx_dm,
    output logic             out_bit,
    output logic             bs_sending,
    output logic             rx_active,
    output logic             pkt_end,
    output logic             rx_error,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);

    line_state_t      line_state;
    logic             dec_bit;
    rx_state_t        state;
    logic [2:0]       zero_cnt;
    logic [OnesW-1:0] ones_cnt;

    usb_nrzi_decode u_nrzi (
        .clock      (clock),
        .reset      (reset),
        .rx_dp      (rx_dp),
        .rx_dm      (rx_dm),
        .line_state (line_state),
        .dec_bit    (dec_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= StIdle;
            zero_cnt   <= '0;
            ones_cnt   <= '0;
            out_bit    <= 1'b0;
            bs_sending <= 1'b0;
            rx_active  <= 1'b0;
            pkt_end    <= 1'b0;
            rx_error   <= 1'b0;
            bit_count  <= '0;
        end else begin
            bs_sending <= 1'b0;
            pkt_end    <= 1'b0;
            rx_error   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (line_state == LsK) begin
                        state    <= StSync;
                        zero_cnt <= 3'd1;
                    end
                end
                StSync: begin
                    if (line_state == LsSe0 || line_state == LsSe1) begin
                        rx_error <= 1'b1;
                        state    <= StAbort;
                    end else if (!dec_bit) begin
                        if (zero_cnt != 3'd7) zero_cnt <= zero_cnt + 3'd1;
                    end else if (zero_cnt < 3'(SyncMinZeros)) begin
                        // Too few alternations to be a SYNC: treat as line noise.
                        state <= StIdle;
                    end else begin
                        // The repeated K that ends SYNC counts as the first 1 of the stuffing run.
                        state     <= StData;
                        rx_active <= 1'b1;
                        bit_count <= '0;
                        ones_cnt  <= OnesW'(1);
                    end
                end
                StData: begin
                    unique case (line_state)
                        LsSe0: state <= StEop1;
                        LsSe1: begin
                            rx_error  <= 1'b1;
                            rx_active <= 1'b0;
                            state     <= StAbort;
                        end
                        default: begin
                            if (ones_cnt == OnesW'(STUFF_LEN)) begin
                                if (dec_bit) begin
                                    rx_error  <= 1'b1;
                                    rx_active <= 1'b0;
                                    state     <= StAbort;
                                end else begin
                                    ones_cnt <= '0;
                                end
                            end else if (bit_count == CNT_W'(MAX_BITS)) begin
                                rx_error  <= 1'b1;
                                rx_active <= 1'b0;
                                state     <= StAbort;
                            end else begin
                                bs_sending <= 1'b1;
                                out_bit    <= dec_bit;
                                bit_count  <= bit_count + CNT_W'(1);
                                ones_cnt   <= dec_bit ? ones_cnt + OnesW'(1) : '0;
                            end
                        end
                    endcase
                end
                StEop1: begin
                    unique case (line_state)
                        LsSe0: state <= StEop2;
                        LsJ: begin
                            pkt_end   <= 1'b1;
                            rx_active <= 1'b0;
                            state     <= StIdle;
                        end
                        default: begin
                            rx_error  <= 1'b1;
                            rx_active <= 1'b0;
                            state     <= StAbort;
                        end
                    endcase
                end
                StEop2: begin
                    if (line_state == LsJ) begin
                        pkt_end <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        rx_error <= 1'b1;
                        state    <= StAbort;
                    end
                    rx_active <= 1'b0;
                end
                StAbort: begin
                    rx_active <= 1'b0;
                    if (line_state == LsJ) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
